// File: rtl/regfile_cc_pkg.sv
// Shared constants and the flag-to-NZP encoder for the LC-3b register file / CC unit.
package regfile_cc_pkg;

   localparam int unsigned REG_ADDR_W = 3;
   localparam logic [2:0]  CC_RESET   = 3'b010;
   localparam int unsigned CC_N       = 2;
   localparam int unsigned CC_Z       = 1;
   localparam int unsigned CC_P       = 0;

   // neg wins over zero so exactly one of N/Z/P is ever set
   function automatic logic [2:0] encode_cc(input logic zero, input logic neg);
      logic [2:0] nzp;
      nzp       = '0;
      nzp[CC_N] = neg;
      nzp[CC_Z] = zero & ~neg;
      nzp[CC_P] = ~neg & ~zero;
      return nzp;
   endfunction

endpackage

// File: rtl/regfile_cc_cc_reg.sv
// Condition-code register: encodes ALU flags into N/Z/P, holds them, and evaluates branch taken.
module cc_reg
   import regfile_cc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_cc,
   input  logic       alu_zero,
   input  logic       alu_neg,
   input  logic [2:0] nzp_mask,
   output logic [2:0] cc,
   output logic       br_taken
);

   logic [2:0] cc_d;
   logic [2:0] cc_q;

   always_comb begin
      // NOTE: default first so every path assigns cc_d and no latch is inferred.
      cc_d = cc_q;
      if (ld_cc) begin
         cc_d = encode_cc(alu_zero, alu_neg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking for state so every flop samples pre-edge values.
      if (!rst_n) begin
         cc_q <= CC_RESET;
      end else begin
         cc_q <= cc_d;
      end
   end

   // Branch sees only the registered codes; this cycle's flags are not bypassed.
   assign cc       = cc_q;
   assign br_taken = |(nzp_mask & cc_q);

endmodule

// File: rtl/regfile_cc.sv
// LC-3b register file with write-through bypass, per-register busy scoreboard and CC unit.
module regfile_cc
   import regfile_cc_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] sr1_addr,
   input  logic [REG_ADDR_W-1:0] sr2_addr,
   output logic [DATA_W-1:0]     sr1_data,
   output logic [DATA_W-1:0]     sr2_data,
   output logic                  sr1_busy,
   output logic                  sr2_busy,
   input  logic                  issue_en,
   input  logic [REG_ADDR_W-1:0] issue_dst,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  ld_cc,
   input  logic                  alu_zero,
   input  logic                  alu_neg,
   input  logic [2:0]            nzp_mask,
   output logic [2:0]            cc,
   output logic                  br_taken
);

   logic [NREGS-1:0][DATA_W-1:0] regs_d;
   logic [NREGS-1:0][DATA_W-1:0] regs_q;
   logic [NREGS-1:0]             busy_d;
   logic [NREGS-1:0]             busy_q;
   logic                         byp1;
   logic                         byp2;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
         busy_d[wr_addr] = 1'b0;
      end
      // Applied after the clear so a same-cycle issue keeps the register busy.
      if (issue_en) begin
         busy_d[issue_dst] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset because reads of unwritten registers must return 0.
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign byp1     = wr_en && (wr_addr == sr1_addr);
   assign byp2     = wr_en && (wr_addr == sr2_addr);
   assign sr1_data = byp1 ? wr_data : regs_q[sr1_addr];
   assign sr2_data = byp2 ? wr_data : regs_q[sr2_addr];
   assign sr1_busy = busy_q[sr1_addr] & ~byp1;
   assign sr2_busy = busy_q[sr2_addr] & ~byp2;

   cc_reg u_cc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_cc    (ld_cc),
      .alu_zero (alu_zero),
      .alu_neg  (alu_neg),
      .nzp_mask (nzp_mask),
      .cc       (cc),
      .br_taken (br_taken)
   );

endmodule

// File: tb/tb_regfile_cc.sv
// Directed bench for regfile_cc: inputs change on the falling edge, outputs are read 1ns later.
module tb_regfile_cc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  sr1_addr, sr2_addr, issue_dst, wr_addr, nzp_mask;
   logic [15:0] sr1_data, sr2_data, wr_data;
   logic        sr1_busy, sr2_busy, issue_en, wr_en, ld_cc, alu_zero, alu_neg;
   logic [2:0]  cc;
   logic        br_taken;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_cc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sr1_addr  (sr1_addr),
      .sr2_addr  (sr2_addr),
      .sr1_data  (sr1_data),
      .sr2_data  (sr2_data),
      .sr1_busy  (sr1_busy),
      .sr2_busy  (sr2_busy),
      .issue_en  (issue_en),
      .issue_dst (issue_dst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .ld_cc     (ld_cc),
      .alu_zero  (alu_zero),
      .alu_neg   (alu_neg),
      .nzp_mask  (nzp_mask),
      .cc        (cc),
      .br_taken  (br_taken)
   );

   task automatic idle();
      issue_en = 1'b0;
      wr_en    = 1'b0;
      ld_cc    = 1'b0;
      alu_zero = 1'b0;
      alu_neg  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle();
      issue_dst = 3'd0; wr_addr = 3'd0; wr_data = 16'h0;
      sr1_addr = 3'd0; sr2_addr = 3'd0; nzp_mask = 3'b000;
      #12;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sr1_addr = 3'(i); sr2_addr = 3'(7 - i);
         #1;
         total++;
         if (sr1_data !== 16'h0 || sr2_data !== 16'h0) begin
            bad++; $display("FAIL reset_read[%0d] got sr1=%h sr2=%h want 0000 0000", i, sr1_data, sr2_data);
         end
         total++;
         if (sr1_busy !== 1'b0 || sr2_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy[%0d] got %b%b want 00", i, sr1_busy, sr2_busy);
         end
      end
      total++;
      if (cc !== 3'b010) begin bad++; $display("FAIL reset_cc got %b want 010", cc); end
      nzp_mask = 3'b010; #1;
      total++;
      if (br_taken !== 1'b1) begin bad++; $display("FAIL reset_br_z got %b want 1", br_taken); end
      nzp_mask = 3'b101; #1;
      total++;
      if (br_taken !== 1'b0) begin bad++; $display("FAIL reset_br_np got %b want 0", br_taken); end
   endtask

   task automatic test_write_bypass();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; sr1_addr = 3'd3; sr2_addr = 3'd2;
      #1;
      total++;
      if (sr1_data !== 16'h1234) begin bad++; $display("FAIL bypass_r3 got %h want 1234", sr1_data); end
      total++;
      if (sr2_data !== 16'h0000) begin bad++; $display("FAIL bypass_r2 got %h want 0000", sr2_data); end
      @(negedge clk); idle(); #1;
      total++;
      if (sr1_data !== 16'h1234) begin bad++; $display("FAIL stored_r3 got %h want 1234", sr1_data); end
      total++;
      if (sr2_data !== 16'h0000) begin bad++; $display("FAIL stored_r2 got %h want 0000", sr2_data); end
      total++;
      if (sr1_busy !== 1'b0) begin bad++; $display("FAIL r3_not_busy got %b want 0", sr1_busy); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      issue_en = 1'b1; issue_dst = 3'd5; sr2_addr = 3'd5; sr1_addr = 3'd3;
      #1;
      total++;
      if (sr2_busy !== 1'b0) begin bad++; $display("FAIL busy_pre_edge got %b want 0", sr2_busy); end
      @(negedge clk); idle(); #1;
      total++;
      if (sr2_busy !== 1'b1) begin bad++; $display("FAIL busy_r5 got %b want 1", sr2_busy); end
      total++;
      if (sr1_busy !== 1'b0) begin bad++; $display("FAIL busy_r3 got %b want 0", sr1_busy); end
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00FF;
      #1;
      total++;
      if (sr2_busy !== 1'b0 || sr2_data !== 16'h00FF) begin
         bad++; $display("FAIL wb_r5_same got busy=%b data=%h want 0 00ff", sr2_busy, sr2_data);
      end
      @(negedge clk); idle(); #1;
      total++;
      if (sr2_busy !== 1'b0 || sr2_data !== 16'h00FF) begin
         bad++; $display("FAIL wb_r5_next got busy=%b data=%h want 0 00ff", sr2_busy, sr2_data);
      end
   endtask

   task automatic test_same_cycle_issue_wb();
      @(negedge clk);
      issue_en = 1'b1; issue_dst = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hABCD; sr1_addr = 3'd4;
      #1;
      total++;
      if (sr1_busy !== 1'b0) begin bad++; $display("FAIL same_cyc_byp_busy got %b want 0", sr1_busy); end
      @(negedge clk); idle(); #1;
      total++;
      if (sr1_busy !== 1'b1) begin bad++; $display("FAIL same_cyc_busy got %b want 1", sr1_busy); end
      total++;
      if (sr1_data !== 16'hABCD) begin bad++; $display("FAIL same_cyc_data got %h want abcd", sr1_data); end
   endtask

   task automatic test_cc();
      logic [1:0] flags [4] = '{2'b01, 2'b10, 2'b00, 2'b11};   // {zero, neg}
      logic [2:0] exp_cc [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
      logic [2:0] prev;
      nzp_mask = 3'b001;
      prev = 3'b010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ld_cc = 1'b1; alu_zero = flags[i][1]; alu_neg = flags[i][0];
         #1;
         total++;
         if (cc !== prev) begin bad++; $display("FAIL cc_latency[%0d] got %b want %b", i, cc, prev); end
         @(negedge clk); idle(); #1;
         total++;
         if (cc !== exp_cc[i]) begin bad++; $display("FAIL cc_load[%0d] got %b want %b", i, cc, exp_cc[i]); end
         total++;
         if (br_taken !== (i == 2)) begin
            bad++; $display("FAIL br_p[%0d] got %b want %b", i, br_taken, (i == 2));
         end
         prev = exp_cc[i];
      end
      @(negedge clk); #1;
      total++;
      if (cc !== 3'b100) begin bad++; $display("FAIL cc_hold got %b want 100", cc); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hBEEF;
      ld_cc = 1'b1; alu_zero = 1'b0; alu_neg = 1'b1;
      issue_en = 1'b1; issue_dst = 3'd2;
      @(negedge clk); idle();
      sr1_addr = 3'd7; sr2_addr = 3'd2;
      #1;
      total++;
      if (sr1_data !== 16'hBEEF || sr2_busy !== 1'b1) begin
         bad++; $display("FAIL pre_rst got r7=%h busy2=%b want beef 1", sr1_data, sr2_busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (sr1_data !== 16'h0) begin bad++; $display("FAIL async_r7 got %h want 0000", sr1_data); end
      total++;
      if (cc !== 3'b010) begin bad++; $display("FAIL async_cc got %b want 010", cc); end
      total++;
      if (sr2_busy !== 1'b0) begin bad++; $display("FAIL async_busy got %b want 0", sr2_busy); end
      // a write presented while reset is held must not land
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5555; ld_cc = 1'b1; alu_zero = 1'b0; alu_neg = 1'b0;
      issue_en = 1'b1; issue_dst = 3'd6;
      @(negedge clk); idle(); rst_n = 1'b1; sr1_addr = 3'd6; sr2_addr = 3'd6;
      #1;
      total++;
      if (sr1_data !== 16'h0 || sr2_busy !== 1'b0 || cc !== 3'b010) begin
         bad++; $display("FAIL rst_write_ignored got r6=%h busy=%b cc=%b want 0000 0 010", sr1_data, sr2_busy, cc);
      end
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_scoreboard();
      test_same_cycle_issue_wb();
      test_cc();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_cc.md
# regfile_cc

LC-3b register file and condition-code unit, sitting directly upstream of the ALU and consuming its result. It supplies the two ALU source operands, takes the ALU result back as write-back data, and latches the ALU `zero`/`neg` flags into the N/Z/P register that branch evaluation reads. A per-register busy scoreboard lets issue logic stall on operands whose write-back is still outstanding.

## Interface
Parameters:
- `DATA_W`, 16, register and operand width.
- `NREGS`, 8, number of general registers. Address width is fixed at 3; `NREGS` must be 8.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sr1_addr`  in  3  source-1 register address.
- `sr2_addr`  in  3  source-2 register address.
- `sr1_data`  out  DATA_W  source-1 operand to the ALU `a` input.
- `sr2_data`  out  DATA_W  source-2 operand to the ALU `b` input.
- `sr1_busy`  out  1  the source-1 register has a write-back pending.
- `sr2_busy`  out  1  the source-2 register has a write-back pending.
- `issue_en`  in  1  an instruction is issued that will write `issue_dst`.
- `issue_dst`  in  3  destination register of the issuing instruction.
- `wr_en`  in  1  write-back strobe.
- `wr_addr`  in  3  write-back register address.
- `wr_data`  in  DATA_W  write-back data (ALU `alu_out`).
- `ld_cc`  in  1  load the condition codes this cycle.
- `alu_zero`  in  1  ALU `zero` flag.
- `alu_neg`  in  1  ALU `neg` flag.
- `nzp_mask`  in  3  BR instruction n/z/p bits, bit 2 = n.
- `cc`  out  3  current {N,Z,P}.
- `br_taken`  out  1  `|(nzp_mask & cc)`.

## Operation
- Storage: 8 × DATA_W registers R0–R7. There is no hardwired-zero register.
- Reads are combinational. If `wr_en` is high and `wr_addr` equals the read address, the read returns `wr_data` (write-through bypass). Otherwise it returns the stored value.
- Write: on a rising edge with `wr_en` high, `R[wr_addr]` ← `wr_data`.
- Scoreboard: one busy bit per register.
  - `issue_en` sets `busy[issue_dst]`.
  - `wr_en` clears `busy[wr_addr]`.
  - If both target the same register in the same cycle, the set wins (busy stays 1).
- Busy outputs: `srX_busy = busy[srX_addr]`. The bit is forced to 0 when `wr_en` is high with `wr_addr == srX_addr`, because the data is bypassed that cycle.
- Condition codes: on a rising edge with `ld_cc` high, `cc` ← {`alu_neg`, `alu_zero & ~alu_neg`, `~alu_neg & ~alu_zero`}.
  - `neg` has priority if both flags are asserted, so exactly one bit of `cc` is always set.
  - When `ld_cc` is low, `cc` holds its value.
- `br_taken` is evaluated from the registered `cc` only. There is no bypass from this cycle's ALU flags.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - all registers = 0;
  - all busy bits = 0;
  - `cc` = 3'b010 (Z).
- Output values at reset:
  - `sr1_data` and `sr2_data` = 0, unless bypass applies;
  - `sr1_busy` and `sr2_busy` = 0;
  - `br_taken` = `nzp_mask[1]`.
- Read latency: 0 cycles (combinational).
- Write visibility: the same cycle through the bypass; the following cycle from storage.
- Condition-code latency: 1 cycle from `ld_cc` to the new value on `cc` and `br_taken`.
- Reset asserted mid-operation discards any write or condition-code load in flight that cycle. A write arriving with `rst_n` low is ignored.
- Writing a register that is not busy is legal and leaves its busy bit at 0.

## Structure
- A shared package holds:
  - `REG_ADDR_W` = 3;
  - `CC_RESET` = 3'b010;
  - the CC bit-index constants `CC_N` = 2, `CC_Z` = 1, `CC_P` = 0.
- One sub-module, `cc_reg`: the flag-to-NZP encoder, the CC register and the `br_taken` logic.
- The register array, bypass and scoreboard live in the top level.

## Test plan
- Reset, then read all addresses → every read returns 0, every busy bit is 0, `cc` = 010. With `nzp_mask` = 010, `br_taken` = 1; with `nzp_mask` = 101, `br_taken` = 0.
- Write R3 = 16'h1234, with `sr1_addr` = 3 in the same cycle → `sr1_data` = 1234 in that cycle through the bypass, and still 1234 on the next cycle. R2 stays 0.
- `issue_en` with dst 5, then `sr2_addr` = 5 → `sr2_busy` = 1. Write-back to R5 of 16'h00FF → in that cycle `sr2_busy` = 0 and `sr2_data` = 00FF; the next cycle busy = 0.
- Issue to R4 and write-back to R4 in the same cycle → the next cycle `busy[4]` = 1 and R4 holds the written data.
- `ld_cc` with (zero, neg) = (0,1), then (1,0), then (0,0), then (1,1) → `cc` = 100, 010, 001, 100, each one cycle later. `br_taken` with `nzp_mask` = 001 is 1 only after the (0,0) load.
- Write R7 = 16'hBEEF and `ld_cc` (0,1), then pulse `rst_n` low between edges → R7 = 0, `cc` = 010, busy bits cleared, all immediately and without waiting for a clock edge.
